// File: rtl/ikascc_businit_pkg.sv
// Package for the SCC slot bus initiator.
// Holds the FSM state encoding, the queued command word layout
// {wr, addr[15:0], wdata[7:0]} and the slot wait timeout.
// The optional wait-state feature is controlled by the macro IKASCC_BUSINIT_WAIT_EN.
package ikascc_businit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_GAP    = 3'd4
    } busst_e;

    localparam int CMD_W = 25;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } cmd_t;

    // Number of extra phiM ticks a strobe may be stretched before it is aborted.
    localparam logic [7:0] WAIT_TIMEOUT = 8'd255;

    // Tick counters count down to zero, so a phase of n ticks loads n-1.
    function automatic logic [3:0] tck_load(input int n);
        return 4'(n - 1);
    endfunction

endpackage

// File: rtl/ikascc_businit_fifo.sv
// Synchronous command FIFO with asynchronous active-low reset.
// Ports: clk/rst_n; push+wdata (ignored when full); pop (ignored when empty);
// rdata shows the head entry; full/empty status flags.
module ikascc_businit_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 25
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             push_ok_s, pop_ok_s;

    assign full      = (cnt_q == (AW+1)'(DEPTH));
    assign empty     = (cnt_q == '0);
    assign rdata     = mem_q[rptr_q];
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    // Next-state for storage, pointers (power-of-two depth wraps naturally) and fill count.
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push_ok_s) begin
            mem_d[wptr_q] = wdata;
            wptr_d        = wptr_q + AW'(1);
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_ok_s) begin
            rptr_d = rptr_q + AW'(1);
        end else begin
            rptr_d = rptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/ikascc_bus_initiator.sv
// Cartridge-slot bus master driving the SCC mapper/sound slave from the host side.
// Host commands are queued and replayed as slot cycles SETUP -> STROBE -> HOLD -> GAP,
// timed in phiM ticks (emuclk edges with i_MCLK_PCEN_n low). Read data returns on
// o_RSP_VALID/o_RSP_RDATA in command order.
// Ports: i_EMUCLK/i_RST_n clock and async reset; i_MCLK_PCEN_n tick enable;
// i_REQ_* / o_REQ_READY command queue; o_RSP_* read response; o_BUSY;
// o_CS_n/o_RD_n/o_WR_n/o_ADDR/o_DB/o_DB_OE/i_DB/i_WAIT_n slot pins.
// Optional macro IKASCC_BUSINIT_WAIT_EN: stretch the strobe while i_WAIT_n is low,
// aborting after WAIT_TIMEOUT ticks (aborted reads return 8'hFF).
module ikascc_bus_initiator
    import ikascc_businit_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int SETUP_TCK  = 1,
    parameter int STROBE_TCK = 2,
    parameter int HOLD_TCK   = 1
) (
    input  logic        i_EMUCLK,
    input  logic        i_RST_n,
    input  logic        i_MCLK_PCEN_n,
    input  logic        i_REQ_VALID,
    output logic        o_REQ_READY,
    input  logic        i_REQ_WR,
    input  logic [15:0] i_REQ_ADDR,
    input  logic [7:0]  i_REQ_WDATA,
    output logic        o_RSP_VALID,
    output logic [7:0]  o_RSP_RDATA,
    output logic        o_BUSY,
    output logic        o_CS_n,
    output logic        o_RD_n,
    output logic        o_WR_n,
    output logic [15:0] o_ADDR,
    output logic [7:0]  o_DB,
    output logic        o_DB_OE,
    input  logic [7:0]  i_DB,
    input  logic        i_WAIT_n
);
    busst_e      state_q, state_d;
    logic [3:0]  tcnt_q, tcnt_d;
    logic        cur_wr_q, cur_wr_d;
    logic        cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  db_q, db_d;
    logic        db_oe_q, db_oe_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;
    logic        tick_s, pop_s, strobe_done_s, abort_s;
    logic        fifo_full_s, fifo_empty_s;
    logic [CMD_W-1:0] fifo_rdata_s;
    cmd_t        head_s;
`ifdef IKASCC_BUSINIT_WAIT_EN
    logic [7:0]  wait_cnt_q, wait_cnt_d;
`else
    logic        unused_wait_s;
    assign unused_wait_s = i_WAIT_n;
`endif

    ikascc_businit_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(CMD_W)) u_fifo (
        .clk   (i_EMUCLK),
        .rst_n (i_RST_n),
        .push  (i_REQ_VALID),
        .wdata ({i_REQ_WR, i_REQ_ADDR, i_REQ_WDATA}),
        .pop   (pop_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign head_s      = cmd_t'(fifo_rdata_s);
    assign tick_s      = ~i_MCLK_PCEN_n;
    assign o_REQ_READY = ~fifo_full_s;
    assign o_BUSY      = ~fifo_empty_s | (state_q != ST_IDLE);
    assign o_CS_n      = cs_n_q;
    assign o_RD_n      = rd_n_q;
    assign o_WR_n      = wr_n_q;
    assign o_ADDR      = addr_q;
    assign o_DB        = db_q;
    assign o_DB_OE     = db_oe_q;
    assign o_RSP_VALID = rsp_valid_q;
    assign o_RSP_RDATA = rsp_rdata_q;

    // Slot-cycle sequencing; everything advances only on phiM ticks.
    always_comb begin
        state_d       = state_q;
        tcnt_d        = tcnt_q;
        cur_wr_d      = cur_wr_q;
        cs_n_d        = cs_n_q;
        rd_n_d        = rd_n_q;
        wr_n_d        = wr_n_q;
        addr_d        = addr_q;
        db_d          = db_q;
        db_oe_d       = db_oe_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        pop_s         = 1'b0;
        strobe_done_s = 1'b0;
        abort_s       = 1'b0;
`ifdef IKASCC_BUSINIT_WAIT_EN
        wait_cnt_d    = wait_cnt_q;
`endif
        if (tick_s) begin
            case (state_q)
                // GAP ends straight into the next SETUP so back-to-back
                // cycles still see one tick of CS_n high.
                ST_IDLE, ST_GAP: begin
                    if (!fifo_empty_s) begin
                        pop_s    = 1'b1;
                        state_d  = ST_SETUP;
                        tcnt_d   = tck_load(SETUP_TCK);
                        cur_wr_d = head_s.wr;
                        addr_d   = head_s.addr;
                        cs_n_d   = 1'b0;
                        if (head_s.wr) begin
                            db_d    = head_s.wdata;
                            db_oe_d = 1'b1;
                        end else begin
                            db_oe_d = 1'b0;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    if (tcnt_q == 4'd0) begin
                        state_d = ST_STROBE;
                        tcnt_d  = tck_load(STROBE_TCK);
                        rd_n_d  = cur_wr_q;
                        wr_n_d  = ~cur_wr_q;
`ifdef IKASCC_BUSINIT_WAIT_EN
                        wait_cnt_d = 8'd0;
`endif
                    end else begin
                        tcnt_d = tcnt_q - 4'd1;
                    end
                end
                ST_STROBE: begin
                    if (tcnt_q == 4'd0) begin
`ifdef IKASCC_BUSINIT_WAIT_EN
                        if (!i_WAIT_n && (wait_cnt_q != WAIT_TIMEOUT)) begin
                            wait_cnt_d = wait_cnt_q + 8'd1;
                        end else begin
                            strobe_done_s = 1'b1;
                            abort_s       = ~i_WAIT_n;
                        end
`else
                        strobe_done_s = 1'b1;
`endif
                    end else begin
                        tcnt_d = tcnt_q - 4'd1;
                    end
                    if (strobe_done_s) begin
                        state_d = ST_HOLD;
                        tcnt_d  = tck_load(HOLD_TCK);
                        rd_n_d  = 1'b1;
                        wr_n_d  = 1'b1;
                        if (!cur_wr_q) begin
                            rsp_valid_d = 1'b1;
                            rsp_rdata_d = abort_s ? 8'hFF : i_DB;
                        end else begin
                            rsp_valid_d = 1'b0;
                        end
                    end else begin
                        state_d = ST_STROBE;
                    end
                end
                ST_HOLD: begin
                    if (tcnt_q == 4'd0) begin
                        state_d = ST_GAP;
                        cs_n_d  = 1'b1;
                        db_oe_d = 1'b0;
                    end else begin
                        tcnt_d = tcnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cs_n_d  = 1'b1;
                    rd_n_d  = 1'b1;
                    wr_n_d  = 1'b1;
                    db_oe_d = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // FSM state and registered slot/response outputs.
    always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state_q     <= ST_IDLE;
            tcnt_q      <= 4'd0;
            cur_wr_q    <= 1'b0;
            cs_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            addr_q      <= 16'h0000;
            db_q        <= 8'h00;
            db_oe_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
`ifdef IKASCC_BUSINIT_WAIT_EN
            wait_cnt_q  <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            cur_wr_q    <= cur_wr_d;
            cs_n_q      <= cs_n_d;
            rd_n_q      <= rd_n_d;
            wr_n_q      <= wr_n_d;
            addr_q      <= addr_d;
            db_q        <= db_d;
            db_oe_q     <= db_oe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef IKASCC_BUSINIT_WAIT_EN
            wait_cnt_q  <= wait_cnt_d;
`endif
        end
    end

endmodule
